// File: rtl/instr_fetch.sv
// 6502 fetch stage: owns the PC, reads a 3-byte word, trims it to the opcode's length and hands it to decode.
// Optional fetch_cnt_o accepted-instruction counter under `FETCH_CNT_EN.
module instr_fetch #(
    parameter int                       MEM_ADDR_SIZE = 16,
    parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC      = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    input  logic [23:0]              mem_data_i,
    input  logic                     redirect_i,
    input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [23:0]              instr_o,
    output logic [1:0]               instr_len_o,
    output logic [MEM_ADDR_SIZE-1:0] instr_pc_o
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]              fetch_cnt_o
`endif
);

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_VALID} state_t;

    state_t                   state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
    logic [23:0]              instr_q, instr_d;
    logic [1:0]               len_q, len_d;
    logic [MEM_ADDR_SIZE-1:0] ipc_q, ipc_d;
    logic [1:0]               op_len;
    logic                     accept;

    // Length from the opcode's bbb (bits 4:2) and cc (bits 1:0) groups.
    always_comb begin
        logic [2:0] bbb;
        bbb    = mem_data_i[4:2];
        op_len = 2'd1;
        unique case (mem_data_i[1:0])
            2'b01: op_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
            2'b10: begin
                if (bbb == 3'b011 || bbb == 3'b111)                         op_len = 2'd3;
                else if (bbb == 3'b000 || bbb == 3'b001 || bbb == 3'b101)   op_len = 2'd2;
                else                                                        op_len = 2'd1;
            end
            2'b00: begin
                if (bbb == 3'b000) begin
                    if (mem_data_i[7:5] == 3'b001)                          op_len = 2'd3;
                    else if (mem_data_i[7:5] == 3'b000 || mem_data_i[7:5] == 3'b010
                             || mem_data_i[7:5] == 3'b011)                  op_len = 2'd1;
                    else                                                    op_len = 2'd2;
                end
                else if (bbb == 3'b010 || bbb == 3'b110)                    op_len = 2'd1;
                else if (bbb == 3'b011 || bbb == 3'b111)                    op_len = 2'd3;
                else                                                        op_len = 2'd2;
            end
            default: op_len = 2'd1;
        endcase
    end

    assign accept        = (state_q == ST_VALID) && instr_ready_i;
    assign mem_addr_o    = pc_q;
    assign instr_valid_o = (state_q == ST_VALID);
    assign instr_o       = instr_q;
    assign instr_len_o   = len_q;
    assign instr_pc_o    = ipc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        len_d   = len_q;
        ipc_d   = ipc_q;
        case (state_q)
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                len_d   = op_len;
                ipc_d   = pc_q;
                state_d = ST_VALID;
                case (op_len)
                    2'd1:    instr_d = {16'h0000, mem_data_i[7:0]};
                    2'd2:    instr_d = {8'h00, mem_data_i[15:0]};
                    default: instr_d = mem_data_i;
                endcase
            end
            ST_VALID: begin
                if (instr_ready_i) begin
                    pc_d    = pc_q + MEM_ADDR_SIZE'(len_q);
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
        // Redirect beats everything, including an accept in the same cycle.
        if (redirect_i) begin
            pc_d    = redirect_pc_i;
            state_d = ST_ISSUE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            len_q   <= 2'd1;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            len_q   <= len_d;
            ipc_q   <= ipc_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)       cnt_q <= '0;
        else if (accept) cnt_q <= cnt_q + 16'd1;
    end
    assign fetch_cnt_o = cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a byte-array memory model that returns data one cycle after the address.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] mem_addr_o;
    logic [23:0] mem_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [23:0] instr_o;
    logic [1:0]  instr_len_o;
    logic [15:0] instr_pc_o;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:65535];

    instr_fetch #(.MEM_ADDR_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk_i(clk), .rst_i(rst_i), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_len_o(instr_len_o), .instr_pc_o(instr_pc_o)
`ifdef FETCH_CNT_EN
        , .fetch_cnt_o(fetch_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [15:0] a1, a2;
        a1 = mem_addr_o + 16'd1;
        a2 = mem_addr_o + 16'd2;
        mem_data_i <= {mem[a2], mem[a1], mem[mem_addr_o]};
    end

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid_o === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL %s: instr_valid_o timeout, got %b want 1", name, instr_valid_o);
        end
    endtask

    task automatic redirect_to(input logic [15:0] target);
        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = target;
        @(negedge clk);
        redirect_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
        checks++; if (instr_o !== 24'h0) begin errors++; $display("FAIL reset_instr: got %h want 000000", instr_o); end
        checks++; if (instr_len_o !== 2'd1) begin errors++; $display("FAIL reset_len: got %0d want 1", instr_len_o); end
        checks++; if (instr_pc_o !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h want 0000", instr_pc_o); end
        checks++; if (mem_addr_o !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr_o); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", fetch_cnt_o); end
`endif
    endtask

    task automatic test_program();
        mem[0] = 8'h09; mem[1] = 8'hFF; mem[2] = 8'hFF;
        mem[3] = 8'h29; mem[4] = 8'hFF; mem[5] = 8'hFF;
        instr_ready_i = 1'b1;
        do_reset();
        wait_valid("prog0");
        checks++; if (instr_o !== 24'h00FF09 || instr_len_o !== 2'd2 || instr_pc_o !== 16'h0000) begin
            errors++; $display("FAIL prog0: got %h/%0d/%h want 00ff09/2/0000", instr_o, instr_len_o, instr_pc_o); end
        wait_valid("prog1");
        checks++; if (instr_o !== 24'h0000FF || instr_len_o !== 2'd1 || instr_pc_o !== 16'h0002) begin
            errors++; $display("FAIL prog1: got %h/%0d/%h want 0000ff/1/0002", instr_o, instr_len_o, instr_pc_o); end
        wait_valid("prog2");
        checks++; if (instr_o !== 24'h00FF29 || instr_len_o !== 2'd2 || instr_pc_o !== 16'h0003) begin
            errors++; $display("FAIL prog2: got %h/%0d/%h want 00ff29/2/0003", instr_o, instr_len_o, instr_pc_o); end
    endtask

    task automatic test_abs();
        mem[0] = 8'h0D; mem[1] = 8'h05; mem[2] = 8'h00;
        instr_ready_i = 1'b1;
        do_reset();
        wait_valid("abs");
        checks++; if (instr_o !== 24'h00050D || instr_len_o !== 2'd3) begin
            errors++; $display("FAIL abs_instr: got %h/%0d want 00050d/3", instr_o, instr_len_o); end
        @(negedge clk);
        checks++; if (mem_addr_o !== 16'h0003 || instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL abs_next_addr: got %h/%b want 0003/0", mem_addr_o, instr_valid_o); end
    endtask

    task automatic test_stall();
        mem[0] = 8'hA9; mem[1] = 8'h42; mem[2] = 8'hEA; mem[3] = 8'hEA;
        instr_ready_i = 1'b0;
        do_reset();
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (instr_valid_o !== 1'b1 || instr_o !== 24'h0042A9 || instr_len_o !== 2'd2
                          || instr_pc_o !== 16'h0 || mem_addr_o !== 16'h0) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b %h/%0d/%h addr=%h want 1 0042a9/2/0000 addr=0000",
                                   i, instr_valid_o, instr_o, instr_len_o, instr_pc_o, mem_addr_o); end
        end
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
        checks++; if (mem_addr_o !== 16'h0002 || instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL stall_release: got addr=%h v=%b want 0002/0", mem_addr_o, instr_valid_o); end
        wait_valid("stall_next");
        repeat (3) @(negedge clk);
        checks++; if (instr_pc_o !== 16'h0002 || mem_addr_o !== 16'h0002 || instr_o !== 24'h0000EA) begin
            errors++; $display("FAIL stall_once: got pc=%h addr=%h instr=%h want 0002/0002/0000ea", instr_pc_o, mem_addr_o, instr_o); end
    endtask

    task automatic test_redirect_wait();
        mem[0] = 8'hEA; mem[16'h0100] = 8'hA9; mem[16'h0101] = 8'h7F; mem[16'h0102] = 8'h33;
        instr_ready_i = 1'b1;
        do_reset();
        @(posedge clk);
        #1 redirect_i = 1'b1; redirect_pc_i = 16'h0100;
        @(posedge clk);
        #1 redirect_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 16'h0100) begin
            errors++; $display("FAIL redir_wait: got v=%b addr=%h want 0/0100", instr_valid_o, mem_addr_o); end
        wait_valid("redir_wait_next");
        checks++; if (instr_pc_o !== 16'h0100 || instr_o !== 24'h007FA9 || instr_len_o !== 2'd2) begin
            errors++; $display("FAIL redir_wait_instr: got %h/%h/%0d want 0100/007fa9/2", instr_pc_o, instr_o, instr_len_o); end
    endtask

    task automatic test_redirect_accept();
        logic [15:0] cnt0;
        mem[16'h0100] = 8'hEA;
        instr_ready_i = 1'b1;
        redirect_to(16'h0100);
        wait_valid("redir_acc");
`ifdef FETCH_CNT_EN
        cnt0 = fetch_cnt_o;
`else
        cnt0 = 16'h0;
`endif
        redirect_i = 1'b1; redirect_pc_i = 16'h0400;
        @(negedge clk);
        redirect_i = 1'b0;
        checks++; if (mem_addr_o !== 16'h0400 || instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL redir_accept_addr: got %h/%b want 0400/0", mem_addr_o, instr_valid_o); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_cnt_o !== cnt0 + 16'd1) begin
            errors++; $display("FAIL redir_accept_cnt: got %h want %h", fetch_cnt_o, cnt0 + 16'd1); end
`endif
    endtask

    task automatic test_wrap();
        mem[16'hFFFE] = 8'h0D; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        instr_ready_i = 1'b1;
        do_reset();
        redirect_to(16'hFFFE);
        wait_valid("wrap");
        checks++; if (instr_o !== 24'h12340D || instr_len_o !== 2'd3 || instr_pc_o !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_instr: got %h/%0d/%h want 12340d/3/fffe", instr_o, instr_len_o, instr_pc_o); end
        @(negedge clk);
        checks++; if (mem_addr_o !== 16'h0001) begin
            errors++; $display("FAIL wrap_pc: got %h want 0001", mem_addr_o); end
    endtask

    task automatic test_len_decode();
        logic [7:0] ops  [0:21];
        logic [1:0] lens [0:21];
        ops = '{8'h00, 8'h20, 8'h40, 8'h60, 8'hA0, 8'h4C, 8'h08, 8'h24, 8'h10, 8'h18, 8'h1C,
                8'h0A, 8'hA2, 8'hAE, 8'hBE, 8'h96, 8'h9A, 8'h01, 8'h19, 8'h1D, 8'h11, 8'h03};
        lens = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3,
                 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
        instr_ready_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            logic [15:0] a;
            logic [23:0] exp;
            a = 16'h0200 + 16'(i * 4);
            mem[a] = ops[i]; mem[a + 16'd1] = 8'h11; mem[a + 16'd2] = 8'h22;
            exp = (lens[i] == 2'd1) ? {16'h0, ops[i]} : (lens[i] == 2'd2) ? {8'h0, 8'h11, ops[i]} : {8'h22, 8'h11, ops[i]};
            redirect_to(a);
            wait_valid("len");
            checks++; if (instr_len_o !== lens[i] || instr_o !== exp || instr_pc_o !== a) begin
                errors++; $display("FAIL len_%h: got %0d/%h/%h want %0d/%h/%h", ops[i], instr_len_o, instr_o, instr_pc_o, lens[i], exp, a); end
        end
    endtask

    task automatic test_reset_valid();
        mem[0] = 8'hEA; mem[1] = 8'hEA; mem[2] = 8'hEA; mem[3] = 8'hEA;
        instr_ready_i = 1'b0;
        redirect_to(16'h0000);
        wait_valid("rst_valid");
        rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h0300;
        @(posedge clk);
        #1 rst_i = 1'b0; redirect_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 16'h0000) begin
            errors++; $display("FAIL rst_mid: got v=%b addr=%h want 0/0000", instr_valid_o, mem_addr_o); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_cnt_o !== 16'h0) begin
            errors++; $display("FAIL rst_mid_cnt: got %h want 0000", fetch_cnt_o); end
`endif
        instr_ready_i = 1'b1;
        repeat (3) wait_valid("rst_accept");
        @(negedge clk);
        instr_ready_i = 1'b0;
        checks++; if (mem_addr_o !== 16'h0003) begin
            errors++; $display("FAIL rst_accept_addr: got %h want 0003", mem_addr_o); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_cnt_o !== 16'd3) begin
            errors++; $display("FAIL rst_accept_cnt: got %0d want 3", fetch_cnt_o); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_program();
        test_abs();
        test_stall();
        test_redirect_wait();
        test_redirect_accept();
        test_wrap();
        test_len_decode();
        test_reset_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
